fcp6_slave: RTL and testbench

//  FCP6 bus target: downstream consumer of the FCP6 master on the shared data[1:0]/ack/ctrl[1:0] bus.

---
 rtl/fcp6_pkg.sv | 28 ++
 rtl/fcp6_dibit_shift.sv | 45 ++++
 rtl/fcp6_slave.sv | 213 +++++++++++++++++++++
 tb/tb_fcp6_slave.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcp6_pkg.sv
// Shared encodings and state type for the FCP6 bus target.
package fcp6_pkg;

   localparam logic [1:0] CTRL_IDLE = 2'b00;
   localparam logic [1:0] CTRL_MSTR = 2'b01;
   localparam logic [1:0] CTRL_SLV  = 2'b10;
   localparam logic [1:0] CTRL_STOP = 2'b11;

   localparam logic ACK_OK  = 1'b0;
   localparam logic ACK_NAK = 1'b1;

   // Bit index of the read/write flag within the header byte
   localparam logic [2:0] HDR_RW_BIT = 3'd0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR,
      ST_H_ACK,
      ST_W_DATA,
      ST_W_ACK,
      ST_R_REQ,
      ST_R_LOAD,
      ST_RD_DATA,
      ST_R_ACK,
      ST_WAIT_END
   } state_e;

endpackage

// File: rtl/fcp6_dibit_shift.sv
// 8-bit MSB-first dibit shifter with a 2-bit dibit counter; shared by header, write and read paths.
module fcp6_dibit_shift (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       clr,
   input  logic       shift,
   input  logic [7:0] load_val,
   input  logic [1:0] din,
   output logic [7:0] q,
   output logic [1:0] cnt
);

   logic [7:0] sh_q, sh_d;
   logic [1:0] cnt_q, cnt_d;

   // Load wins over clear, clear wins over shift; counter wraps 3->0 at a byte boundary
   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      if (load) begin
         sh_d  = load_val;
         cnt_d = 2'd0;
      end else if (clr) begin
         cnt_d = 2'd0;
      end else if (shift) begin
         sh_d  = {sh_q[5:0], din};
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end

   assign q   = sh_q;
   assign cnt = cnt_q;

endmodule

// File: rtl/fcp6_slave.sv
// FCP6 bus target: header decode, write deserialisation and read serialisation on the shared dibit bus.
module fcp6_slave
   import fcp6_pkg::*;
#(
   parameter logic [6:0]  ADDR    = 7'h2A,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire  [1:0] data,
   inout  wire        ack,
   inout  wire  [1:0] ctrl,
   output logic       wr_valid,
   output logic [7:0] wr_data,
   input  logic       wr_ready,
   output logic       rd_req,
   input  logic [7:0] rd_data,
   output logic       selected,
   output logic       abort
);

   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   state_e          state_q, state_d;
   logic            selected_q, selected_d;
   logic            wr_valid_q, wr_valid_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic            rd_req_q, rd_req_d;
   logic            abort_q, abort_d;
   logic            ack_val_q, ack_val_d;
   logic            ack_oe_q, ack_oe_d;
   logic            data_oe_q, data_oe_d;
   logic            ctrl_oe_q, ctrl_oe_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   logic       sh_load, sh_clr, sh_shift;
   logic [1:0] sh_din;
   logic [7:0] sh_q;
   logic [1:0] sh_cnt;
   logic [7:0] byte_next;
   logic       last_dibit;

   fcp6_dibit_shift u_shift (
      .clk      (clk),
      .rst      (rst),
      .load     (sh_load),
      .clr      (sh_clr),
      .shift    (sh_shift),
      .load_val (rd_data),
      .din      (sh_din),
      .q        (sh_q),
      .cnt      (sh_cnt)
   );

   assign byte_next  = {sh_q[5:0], data};
   assign last_dibit = (sh_cnt == 2'd3);

   always_comb begin
      state_d    = state_q;
      selected_d = selected_q;
      wr_valid_d = 1'b0;
      wr_data_d  = wr_data_q;
      abort_d    = 1'b0;
      ack_val_d  = ack_val_q;
      to_cnt_d   = '0;
      sh_load    = 1'b0;
      sh_clr     = 1'b0;
      sh_shift   = 1'b0;
      sh_din     = data;

      unique case (state_q)
         ST_IDLE: begin
            if (ctrl == CTRL_MSTR) begin
               sh_shift = 1'b1;
               state_d  = ST_HDR;
            end
         end
         ST_HDR: begin
            if (ctrl == CTRL_STOP) begin
               state_d = ST_IDLE;
            end else if (ctrl == CTRL_SLV) begin
               abort_d = 1'b1;
               state_d = ST_WAIT_END;
            end else if (ctrl == CTRL_MSTR) begin
               sh_shift = 1'b1;
               if (last_dibit) begin
                  ack_val_d = (byte_next[7:1] == ADDR) ? ACK_OK : ACK_NAK;
                  state_d   = ST_H_ACK;
               end
            end
         end
         // ack_val_q doubles as the address-match flag while in H_ACK
         ST_H_ACK: begin
            if (ctrl == CTRL_STOP) begin
               state_d = ST_IDLE;
            end else if (ack_val_q == ACK_OK) begin
               selected_d = 1'b1;
               state_d    = sh_q[HDR_RW_BIT] ? ST_W_DATA : ST_R_REQ;
            end else begin
               state_d = ST_WAIT_END;
            end
         end
         ST_W_DATA: begin
            if (ctrl == CTRL_STOP) begin
               state_d = ST_IDLE;
            end else if (ctrl == CTRL_SLV) begin
               abort_d = 1'b1;
               state_d = ST_WAIT_END;
            end else if (ctrl == CTRL_MSTR) begin
               sh_shift = 1'b1;
               if (last_dibit) begin
                  ack_val_d = wr_ready ? ACK_OK : ACK_NAK;
                  if (wr_ready) begin
                     wr_valid_d = 1'b1;
                     wr_data_d  = byte_next;
                  end
                  state_d = ST_W_ACK;
               end
            end
         end
         ST_W_ACK:   state_d = (ctrl == CTRL_STOP) ? ST_IDLE : ST_W_DATA;
         ST_R_REQ:   state_d = (ctrl == CTRL_STOP) ? ST_IDLE : ST_R_LOAD;
         ST_R_LOAD: begin
            if (ctrl == CTRL_STOP) begin
               state_d = ST_IDLE;
            end else begin
               sh_load = 1'b1;
               state_d = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (ctrl == CTRL_STOP) begin
               abort_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               sh_shift = 1'b1;
               sh_din   = 2'b00;
               if (last_dibit) state_d = ST_R_ACK;
            end
         end
         // Anything other than a clean 0 (including Z/X) is a NACK
         ST_R_ACK: begin
            if (ctrl == CTRL_STOP)   state_d = ST_IDLE;
            else if (ack == ACK_OK)  state_d = ST_R_REQ;
            else                     state_d = ST_WAIT_END;
         end
         ST_WAIT_END: begin
            if (ctrl == CTRL_STOP) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Saturating run-length of idle ctrl outside IDLE
      if (state_q != ST_IDLE && ctrl == CTRL_IDLE) begin
         to_cnt_d = (to_cnt_q == TO_W'(TIMEOUT)) ? to_cnt_q : to_cnt_q + TO_W'(1);
         if (to_cnt_d == TO_W'(TIMEOUT)) begin
            abort_d    = 1'b1;
            wr_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      end

      if (state_d == ST_IDLE) begin
         selected_d = 1'b0;
         sh_clr     = 1'b1;
      end
   end

   // Bus enables and rd_req follow the registered next state
   assign rd_req_d  = (state_d == ST_R_REQ);
   assign data_oe_d = (state_d == ST_RD_DATA);
   assign ctrl_oe_d = (state_d == ST_RD_DATA);
   assign ack_oe_d  = (state_d == ST_H_ACK) || (state_d == ST_W_ACK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         selected_q <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_data_q  <= '0;
         rd_req_q   <= 1'b0;
         abort_q    <= 1'b0;
         ack_val_q  <= 1'b0;
         ack_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         ctrl_oe_q  <= 1'b0;
         to_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         selected_q <= selected_d;
         wr_valid_q <= wr_valid_d;
         wr_data_q  <= wr_data_d;
         rd_req_q   <= rd_req_d;
         abort_q    <= abort_d;
         ack_val_q  <= ack_val_d;
         ack_oe_q   <= ack_oe_d;
         data_oe_q  <= data_oe_d;
         ctrl_oe_q  <= ctrl_oe_d;
         to_cnt_q   <= to_cnt_d;
      end
   end

   assign data = data_oe_q ? sh_q[7:6] : 2'bzz;
   assign ctrl = ctrl_oe_q ? CTRL_SLV  : 2'bzz;
   assign ack  = ack_oe_q  ? ack_val_q : 1'bz;

   assign wr_valid = wr_valid_q;
   assign wr_data  = wr_data_q;
   assign rd_req   = rd_req_q;
   assign selected = selected_q;
   assign abort    = abort_q;

endmodule

// File: tb/tb_fcp6_slave.sv
// Self-checking bench for fcp6_slave: bus master model, write vector table, directed corners and random traffic.
module tb_fcp6_slave;
   import fcp6_pkg::*;

   localparam logic [6:0] ADDR = 7'h2A;

   logic       clk = 1'b0;
   logic       rst;
   wire  [1:0] data;
   wire        ack;
   wire  [1:0] ctrl;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       rd_req;
   logic [7:0] rd_data;
   logic       selected;
   logic       abort;

   logic       m_data_oe, m_ctrl_oe, m_ack_oe;
   logic [1:0] m_data, m_ctrl;
   logic       m_ack;

   assign data = m_data_oe ? m_data : 2'bzz;
   assign ctrl = m_ctrl_oe ? m_ctrl : 2'bzz;
   assign ack  = m_ack_oe  ? m_ack  : 1'bz;

   fcp6_slave #(.ADDR(ADDR), .TIMEOUT(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .data     (data),
      .ack      (ack),
      .ctrl     (ctrl),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .selected (selected),
      .abort    (abort)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;
   int n_val = 0, n_req = 0, n_abt = 0, n_slv = 0;

   // Pulse and slave-drive counters sampled just after each edge
   always @(posedge clk) begin
      #1;
      if (wr_valid === 1'b1) n_val++;
      if (rd_req === 1'b1) n_req++;
      if (abort === 1'b1) n_abt++;
      if (ctrl === CTRL_SLV) n_slv++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic bus_idle();
      m_ctrl_oe = 1'b1; m_ctrl = CTRL_IDLE; m_data_oe = 1'b0; m_ack_oe = 1'b0;
   endtask

   task automatic dibit(input logic [1:0] d);
      @(negedge clk);
      m_ctrl_oe = 1'b1; m_ctrl = CTRL_MSTR; m_data_oe = 1'b1; m_data = d;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 4; i++) dibit(b[7-2*i -: 2]);
   endtask

   task automatic stop_bus();
      @(negedge clk);
      m_ctrl_oe = 1'b1; m_ctrl = CTRL_STOP; m_data_oe = 1'b0;
      @(negedge clk);
      m_ctrl = CTRL_IDLE;
   endtask

   task automatic do_write(input logic [6:0] addr, input int nb, input logic [23:0] bytes,
                           input logic [2:0] rdy, output logic hack, output int nval,
                           output logic [7:0] wd);
      int   v0;
      logic hit;
      v0  = n_val;
      hit = (addr == ADDR);
      send_byte({addr, 1'b1});
      @(negedge clk); bus_idle(); hack = ack;
      for (int k = 0; k < nb; k++) begin
         wr_ready = rdy[k];
         send_byte(bytes[8*k +: 8]);
         @(negedge clk); bus_idle();
         if (hit) begin
            chk("w_ack", ack, !rdy[k]);
            chk("w_valid", wr_valid, rdy[k]);
            chk("w_selected", selected, 1);
            if (rdy[k]) chk("w_data", wr_data, bytes[8*k +: 8]);
         end
      end
      stop_bus();
      chk("w_sel_end", selected, 0);
      nval = n_val - v0;
      wd   = wr_data;
   endtask

   task automatic do_read(input int nb, input logic [31:0] rb, input logic [3:0] mack);
      int         s0, q0;
      logic [7:0] b;
      logic [1:0] exp_d;
      s0 = n_slv; q0 = n_req;
      send_byte({ADDR, 1'b0});
      @(negedge clk); m_ctrl_oe = 1'b0; m_data_oe = 1'b0; m_ack_oe = 1'b0;
      chk("r_hdr_ack", ack, 0);
      for (int k = 0; k < nb; k++) begin
         b = rb[8*k +: 8];
         @(negedge clk); m_ack_oe = 1'b0;
         chk("r_req", rd_req, 1);
         rd_data = b;
         @(negedge clk);
         chk("r_load_rel", ctrl === CTRL_SLV, 0);
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_d = 2'((b >> (6 - 2*i)) % 8'd4);
            chk("r_ctrl", ctrl, CTRL_SLV);
            chk("r_dibit", data, exp_d);
         end
         @(negedge clk);
         chk("r_ack_rel", ctrl === CTRL_SLV, 0);
         m_ack_oe = 1'b1; m_ack = mack[k];
      end
      @(negedge clk); m_ack_oe = 1'b0; m_ctrl_oe = 1'b1; m_ctrl = CTRL_STOP;
      @(negedge clk); m_ctrl = CTRL_IDLE;
      chk("r_sel_end", selected, 0);
      chk("r_slv_cycles", n_slv - s0, 4 * nb);
      chk("r_req_count", n_req - q0, nb);
   endtask

   typedef struct {
      logic [6:0]  addr;
      int          nb;
      logic [23:0] bytes;
      logic [2:0]  rdy;
      logic        hack;
      int          nval;
      logic [7:0]  last;
   } vec_t;

   vec_t       vt[5];
   logic       hack;
   int         nval, v0, a0, exp_nval;
   logic [7:0] wd, model_wd;
   logic [6:0] ra;
   logic [23:0] rbytes;
   logic [2:0] rrdy;
   int         rnb;

   initial begin
      vt[0] = '{7'h2A, 1, 24'h0000AA, 3'b001, 1'b0, 1, 8'hAA};
      vt[1] = '{7'h15, 1, 24'h0000AA, 3'b001, 1'b1, 0, 8'hAA};
      vt[2] = '{7'h2A, 2, 24'h00115A, 3'b010, 1'b0, 1, 8'h11};
      vt[3] = '{7'h2A, 3, 24'h80FE01, 3'b111, 1'b0, 3, 8'h80};
      vt[4] = '{7'h2B, 0, 24'h000000, 3'b000, 1'b1, 0, 8'h80};

      rst = 1'b1; wr_ready = 1'b0; rd_data = '0;
      m_ack = 1'b0; m_data = '0; m_ctrl = '0;
      bus_idle();
      repeat (3) @(negedge clk);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_selected", selected, 0);
      chk("rst_abort", abort, 0);
      chk("rst_ctrl_rel", ctrl, CTRL_IDLE);
      rst = 1'b0;
      @(negedge clk);

      // Write vector table
      for (int t = 0; t < 5; t++) begin
         v0 = n_slv;
         do_write(vt[t].addr, vt[t].nb, vt[t].bytes, vt[t].rdy, hack, nval, wd);
         chk("tbl_hdr_ack", hack, vt[t].hack);
         chk("tbl_nvalid", nval, vt[t].nval);
         chk("tbl_wr_data", wd, vt[t].last);
         chk("tbl_no_slv_drive", n_slv - v0, 0);
      end
      model_wd = 8'h80;

      // Two-byte read, ACK then NACK
      do_read(2, 32'h0000C33C, 4'b0010);

      // Stop two dibits into a byte
      v0 = n_val;
      send_byte({ADDR, 1'b1});
      @(negedge clk); bus_idle();
      wr_ready = 1'b1;
      send_byte(8'h77);
      @(negedge clk); bus_idle();
      chk("mid_first_valid", wr_valid, 1);
      dibit(2'b01); dibit(2'b10);
      stop_bus();
      chk("mid_no_valid", wr_valid, 0);
      chk("mid_nvalid", n_val - v0, 1);
      chk("mid_wr_data", wr_data, 8'h77);
      chk("mid_selected", selected, 0);
      model_wd = 8'h77;

      // ctrl=10 during header is a protocol error
      a0 = n_abt;
      dibit(ADDR[6:5]); dibit(ADDR[4:3]);
      @(negedge clk); m_ctrl = CTRL_SLV; m_data_oe = 1'b0;
      @(negedge clk); m_ctrl = CTRL_IDLE;
      chk("perr_abort", abort, 1);
      @(negedge clk);
      chk("perr_abort_pulse", abort, 0);
      send_byte(8'hFF);
      stop_bus();
      chk("perr_abort_count", n_abt - a0, 1);
      chk("perr_sel", selected, 0);

      // Idle-bus timeout in W_DATA
      v0 = n_val;
      send_byte({ADDR, 1'b1});
      @(negedge clk); bus_idle();
      wr_ready = 1'b1;
      send_byte(8'h3C);
      @(negedge clk); bus_idle();
      dibit(2'b11);
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk); bus_idle();
         if (j == 15) chk("to_sel_before", selected, 1);
      end
      chk("to_abort_early", abort, 0);
      @(negedge clk);
      chk("to_abort", abort, 1);
      chk("to_selected", selected, 0);
      @(negedge clk);
      chk("to_abort_pulse", abort, 0);
      chk("to_nvalid", n_val - v0, 1);
      model_wd = 8'h3C;

      // Reset while the slave is driving read data
      send_byte({ADDR, 1'b0});
      @(negedge clk); m_ctrl_oe = 1'b0; m_data_oe = 1'b0;
      @(negedge clk); rd_data = 8'hC0;
      @(negedge clk);
      @(negedge clk);
      chk("rr_ctrl_drv", ctrl, CTRL_SLV);
      chk("rr_data_drv", data, 2'b11);
      rst = 1'b1;
      #1;
      m_ctrl_oe = 1'b1; m_ctrl = CTRL_IDLE; m_data_oe = 1'b1; m_data = 2'b00;
      m_ack_oe = 1'b1; m_ack = 1'b0;
      #1;
      chk("rr_data_rel", data, 2'b00);
      chk("rr_ctrl_rel", ctrl, CTRL_IDLE);
      chk("rr_ack_rel", ack, 0);
      chk("rr_outputs", {wr_valid, rd_req, selected, abort}, 4'b0000);
      chk("rr_wr_data", wr_data, 0);
      @(negedge clk);
      rst = 1'b0; bus_idle();
      @(negedge clk);
      model_wd = 8'h00;

      // Random writes against the behavioural model
      for (int r = 0; r < 20; r++) begin
         ra     = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
         rnb    = $urandom_range(0, 3);
         rbytes = 24'($urandom);
         rrdy   = 3'($urandom);
         exp_nval = 0;
         for (int k = 0; k < rnb; k++) begin
            if (ra == ADDR && rrdy[k]) begin
               exp_nval++;
               model_wd = rbytes[8*k +: 8];
            end
         end
         do_write(ra, rnb, rbytes, rrdy, hack, nval, wd);
         chk("rnd_hdr_ack", hack, ra != ADDR);
         chk("rnd_nvalid", nval, exp_nval);
         chk("rnd_wr_data", wd, model_wd);
      end

      // Random reads: master ACKs every byte but the last
      for (int r = 0; r < 6; r++) begin
         rnb = $urandom_range(1, 3);
         do_read(rnb, $urandom, 4'(1 << (rnb - 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
